// File: rtl/cart_reconfig_seq_pkg.sv
// Shared MSX reconfiguration definitions: sequencer states, default timing
// constants and the per-slot save-required test.
`default_nettype none

package cart_reconfig_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_FLUSH0   = 3'd2,
        ST_FLUSH1   = 3'd3,
        ST_RST_HOLD = 3'd4,
        ST_RELOAD   = 3'd5
    } seq_state_t;

    localparam int unsigned TIMER_W           = 24;
    localparam logic [23:0] DEF_SETTLE_CYCLES = 24'd10_000_000;
    localparam logic [15:0] DEF_RESET_CYCLES  = 16'd1024;
    localparam logic [23:0] DEF_FLUSH_TIMEOUT = 24'd8_000_000;

    function automatic logic slot_needs_flush(input logic [2:0] size, input logic dirty);
        return (size != 3'd0) && dirty;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cart_reconfig_seq_seq_timer.sv
// Loadable down-counter with zero flag, shared by the settle, flush and
// reset-hold phases. Holds at zero instead of wrapping.
`default_nettype none

module cart_reconfig_seq_seq_timer
    import cart_reconfig_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/cart_reconfig_seq.sv
// Cartridge reconfiguration sequencer: waits for the configuration to settle,
// saves dirty SRAM slots, pulses the MSX reset and requests a ROM reload.
`default_nettype none

module cart_reconfig_seq
    import cart_reconfig_seq_pkg::*;
#(
    parameter logic [23:0] SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [15:0] RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter logic [23:0] FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_change,
    input  logic            cart_changed,
    input  logic [1:0][2:0] sram_size,
    input  logic [1:0]      sram_dirty,
    output logic [1:0]      flush_req,
    input  logic            flush_ack,
    output logic            msx_reset,
    output logic            reload_req,
    input  logic            reload_done,
    output logic            busy,
    output logic            flush_timeout
);

    seq_state_t state, state_next;

    logic               cfg_prev;
    logic               pending;
    logic               pending_cart;
    logic               cart_seen;
    logic [1:0][2:0]    size_hold;
    logic [1:0]         dirty_hold;
    logic               change_evt;
    logic               need0;
    logic               need1;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic [TIMER_W-1:0] tmr_value;
    logic               timeout_set;
    logic [1:0]         flush_req_next;

    // cfg_change is a level, so only its rising edge counts as a fresh change
    assign change_evt = (cfg_change & ~cfg_prev) | cart_changed;
    assign need0      = slot_needs_flush(size_hold[0], dirty_hold[0]);
    assign need1      = slot_needs_flush(size_hold[1], dirty_hold[1]);

    cart_reconfig_seq_seq_timer seq_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        tmr_value      = '0;
        timeout_set    = 1'b0;
        flush_req_next = 2'b00;
        case (state)
            ST_IDLE: begin
                if (pending || cfg_change || cart_changed) begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                    tmr_value  = SETTLE_CYCLES - 24'd1;
                end
            end
            ST_SETTLE: begin
                if (change_evt) begin
                    tmr_load  = 1'b1;
                    tmr_value = SETTLE_CYCLES - 24'd1;
                end else if (!cfg_change && !cart_seen) begin
                    state_next = ST_IDLE;
                end else if (tmr_zero) begin
                    state_next = ST_FLUSH0;
                    tmr_load   = 1'b1;
                    tmr_value  = FLUSH_TIMEOUT - 24'd1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_FLUSH0: begin
                if (!need0 || flush_ack) begin
                    state_next = ST_FLUSH1;
                    tmr_load   = 1'b1;
                    tmr_value  = FLUSH_TIMEOUT - 24'd1;
                end else if (tmr_zero) begin
                    state_next  = ST_FLUSH1;
                    tmr_load    = 1'b1;
                    tmr_value   = FLUSH_TIMEOUT - 24'd1;
                    timeout_set = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_FLUSH1: begin
                if (!need1 || flush_ack) begin
                    state_next = ST_RST_HOLD;
                    tmr_load   = 1'b1;
                    tmr_value  = {8'd0, RESET_CYCLES - 16'd1};
                end else if (tmr_zero) begin
                    state_next  = ST_RST_HOLD;
                    tmr_load    = 1'b1;
                    tmr_value   = {8'd0, RESET_CYCLES - 16'd1};
                    timeout_set = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RST_HOLD: begin
                if (tmr_zero) begin
                    state_next = cart_seen ? ST_RELOAD : ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RELOAD: begin
                if (reload_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // On entry to FLUSH0 the hold registers are still loading, so use live inputs
        if (state_next == ST_FLUSH0) begin
            if ((state == ST_SETTLE) ? slot_needs_flush(sram_size[0], sram_dirty[0]) : need0) begin
                flush_req_next = 2'b01;
            end
        end else if ((state_next == ST_FLUSH1) && need1) begin
            flush_req_next = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_prev     <= 1'b0;
            pending      <= 1'b0;
            pending_cart <= 1'b0;
            cart_seen    <= 1'b0;
            size_hold    <= '0;
            dirty_hold   <= '0;
        end else begin
            cfg_prev <= cfg_change;
            if (state == ST_IDLE) begin
                if (state_next == ST_SETTLE) begin
                    cart_seen    <= cart_changed | pending_cart;
                    pending      <= 1'b0;
                    pending_cart <= 1'b0;
                end
            end else if (state == ST_SETTLE) begin
                if (cart_changed) begin
                    cart_seen <= 1'b1;
                end
                if (state_next == ST_FLUSH0) begin
                    size_hold  <= sram_size;
                    dirty_hold <= sram_dirty;
                end
            end else begin
                if (change_evt) begin
                    pending <= 1'b1;
                end
                if (cart_changed) begin
                    pending_cart <= 1'b1;
                end
                if (state_next == ST_IDLE) begin
                    cart_seen <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_req     <= 2'b00;
            msx_reset     <= 1'b0;
            reload_req    <= 1'b0;
            busy          <= 1'b0;
            flush_timeout <= 1'b0;
        end else begin
            flush_req  <= flush_req_next;
            msx_reset  <= (state_next == ST_RST_HOLD) || (state_next == ST_RELOAD);
            reload_req <= (state_next == ST_RELOAD);
            busy       <= (state_next != ST_IDLE);
            if (timeout_set) begin
                flush_timeout <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
